// File: rtl/rptr_empty.sv
// Read-side pointer and flag logic for an asynchronous FIFO.
// Keeps the binary and Gray read pointers and brings the write-domain Gray
// pointer into rclk through a two-flop synchroniser. From these it produces
// registered empty and almost-empty flags, the read-side occupancy count,
// and a sticky underflow flag.
module rptr_empty #(
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic                uf_clr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rd_count,
    output logic                runderflow
);

    localparam int PTRW = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] THRESH = PTRW'(AEMPTY_THRESH);

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b = '0;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDRSIZE:0] r_rbin;
    logic [ADDRSIZE:0] r_rptr;
    logic [ADDRSIZE:0] r_rq1;
    logic [ADDRSIZE:0] r_rq2;
    logic              r_rempty;
    logic              r_raempty;
    logic              r_runderflow;

    logic              w_rd_en;
    logic              w_rd_bad;
    logic [ADDRSIZE:0] w_rbnext;
    logic [ADDRSIZE:0] w_rgnext;
    logic [ADDRSIZE:0] w_wsbin;
    logic [ADDRSIZE:0] w_avail_next;

    // A read only takes effect when data is present. A read while empty is
    // flagged as underflow and leaves the pointers unchanged.
    assign w_rd_en  = rinc & ~r_rempty;
    assign w_rd_bad = rinc & r_rempty;

    // Next pointer values. They feed the flag compares so that a read of the
    // last word raises rempty on the same edge, with no extra cycle.
    assign w_rbnext = r_rbin + {{ADDRSIZE{1'b0}}, w_rd_en};
    assign w_rgnext = (w_rbnext >> 1) ^ w_rbnext;

    // Synchronised write pointer in binary. The occupancy values below wrap
    // modulo 2**(ADDRSIZE+1), and the MSB carries the lap parity.
    assign w_wsbin      = gray2bin(r_rq2);
    assign w_avail_next = w_wsbin - w_rbnext;

    assign rd_count   = w_wsbin - gray2bin(r_rptr);
    assign raddr      = r_rptr[ADDRSIZE-1:0];
    assign rptr       = r_rptr;
    assign rempty     = r_rempty;
    assign raempty    = r_raempty;
    assign runderflow = r_runderflow;

    // Two-flop synchroniser for the write-domain Gray pointer. No logic sits in front of rq1.
    // NOTE: sequential state uses non-blocking assignments. Every flop then samples
    // its pre-edge inputs, so rq2 gets the old rq1 and not this edge's wptr.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_rq1 <= '0;
            r_rq2 <= '0;
        end else begin
            r_rq1 <= wptr;
            r_rq2 <= r_rq1;
        end
    end

    // Read pointers: the binary pointer and its registered Gray copy advance together.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_rbin <= '0;
            r_rptr <= '0;
        end else begin
            r_rbin <= w_rbnext;
            r_rptr <= w_rgnext;
        end
    end

    // Registered empty and almost-empty flags, computed from the next read pointer.
    // The empty test compares the full pointer, including the MSB, so a full FIFO
    // is never reported as empty.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_rempty  <= 1'b1;
            r_raempty <= 1'b1;
        end else begin
            r_rempty  <= (w_rgnext == r_rq2);
            r_raempty <= (w_avail_next <= THRESH);
        end
    end

    // Sticky underflow flag. Setting it takes priority over a clear in the same cycle.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_runderflow <= 1'b0;
        end else if (w_rd_bad) begin
            r_runderflow <= 1'b1;
        end else if (uf_clr) begin
            r_runderflow <= 1'b0;
        end
    end

endmodule
